// File: rtl/crddrop_pkg.sv
// Shared sparse-stream definitions: token format, helpers and the crddrop FSM states.
package crddrop_pkg;

    localparam int unsigned TOKEN_W = 17;

    // Control tokens have bit 16 set; a stop carries its level in [7:0].
    localparam logic [TOKEN_W-1:0] DONE        = 17'h10100;
    localparam logic [8:0]         STOP_PREFIX = 9'h100;

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } crddrop_state_t;

    function automatic logic is_data(input logic [TOKEN_W-1:0] tok);
        return !tok[TOKEN_W-1];
    endfunction

    function automatic logic is_stop(input logic [TOKEN_W-1:0] tok);
        return tok[TOKEN_W-1:8] == STOP_PREFIX;
    endfunction

    function automatic logic is_done(input logic [TOKEN_W-1:0] tok);
        return tok == DONE;
    endfunction

endpackage

// File: rtl/reg_fifo.sv
// Small register-based FIFO; push on full is accepted when a pop happens in the same cycle.
module reg_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 17
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = en_i && pop_i && !empty_o;
    assign do_push = en_i && push_i && (!full_o || do_pop);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage registers; clear also zeroes contents so the head reads 0 afterwards.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/crddrop.sv
// Drops outer coordinates whose inner fiber is empty; forwards the inner stream unchanged.
module crddrop
    import crddrop_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    input  logic               flush,
    input  logic               tile_en,
    input  logic [TOKEN_W-1:0] cmrg_coord_in_0,
    input  logic               cmrg_coord_in_0_valid,
    output logic               cmrg_coord_in_0_ready,
    input  logic [TOKEN_W-1:0] cmrg_coord_in_1,
    input  logic               cmrg_coord_in_1_valid,
    output logic               cmrg_coord_in_1_ready,
    output logic [TOKEN_W-1:0] cmrg_coord_out_0,
    output logic               cmrg_coord_out_0_valid,
    input  logic               cmrg_coord_out_0_ready,
    output logic [TOKEN_W-1:0] cmrg_coord_out_1,
    output logic               cmrg_coord_out_1_valid,
    input  logic               cmrg_coord_out_1_ready
);

    crddrop_state_t     state_q, state_d;
    logic               seen_q, seen_d;
    logic [TOKEN_W-1:0] hold_q, hold_d;

    logic               rst_act;
    logic               in0_rdy, in1_rdy, out0_vld, out1_vld;
    logic               in0_fire, in1_fire;
    logic               f0_push, f1_push, f0_pop, f1_pop;
    logic [TOKEN_W-1:0] f0_wdata, f1_wdata, f0_rdata, f1_rdata;
    logic               f0_full, f0_empty, f1_full, f1_empty;
    logic [3:0]         hs_comb, hs_d, hs_q, hs_out;

    assign rst_act  = !rst_n || flush;
    assign in0_fire = clk_en && cmrg_coord_in_0_valid && in0_rdy;
    assign in1_fire = clk_en && cmrg_coord_in_1_valid && in1_rdy;

    assign out0_vld = tile_en && !f0_empty;
    assign out1_vld = tile_en && !f1_empty;
    assign f0_pop   = out0_vld && cmrg_coord_out_0_ready;
    assign f1_pop   = out1_vld && cmrg_coord_out_1_ready;

    // State register with held coordinate and "fiber non-empty" flag.
    always_ff @(posedge clk) begin
        if (rst_act) begin
            state_q <= StIdle;
            seen_q  <= 1'b0;
            hold_q  <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            seen_q  <= seen_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state: latch outer data, close the fiber on an inner stop or an unconsumed done.
    always_comb begin
        state_d = state_q;
        seen_d  = seen_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (in0_fire && is_data(cmrg_coord_in_0)) begin
                    hold_d  = cmrg_coord_in_0;
                    seen_d  = 1'b0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (in1_fire) begin
                    if (is_data(cmrg_coord_in_1)) begin
                        seen_d = 1'b1;
                    end else begin
                        seen_d  = 1'b0;
                        state_d = StIdle;
                    end
                end else if (clk_en && tile_en && cmrg_coord_in_1_valid &&
                             is_done(cmrg_coord_in_1)) begin
                    seen_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: input readies and FIFO push controls.
    always_comb begin
        in0_rdy  = 1'b0;
        in1_rdy  = 1'b0;
        f0_push  = 1'b0;
        f1_push  = 1'b0;
        f0_wdata = cmrg_coord_in_0;
        f1_wdata = cmrg_coord_in_1;
        if (tile_en) begin
            unique case (state_q)
                StIdle: begin
                    if (cmrg_coord_in_0_valid) begin
                        if (is_done(cmrg_coord_in_0)) begin
                            // Done on both streams is consumed together, never alone.
                            in0_rdy = cmrg_coord_in_1_valid && is_done(cmrg_coord_in_1) &&
                                      !f0_full && !f1_full;
                            in1_rdy = in0_rdy;
                            f0_push = in0_rdy;
                            f1_push = in0_rdy;
                        end else if (is_data(cmrg_coord_in_0)) begin
                            in0_rdy = 1'b1;
                        end else if (is_stop(cmrg_coord_in_0)) begin
                            in0_rdy = !f0_full;
                            f0_push = in0_rdy;
                        end
                    end
                end
                StHold: begin
                    if (cmrg_coord_in_1_valid &&
                        (is_data(cmrg_coord_in_1) || is_stop(cmrg_coord_in_1))) begin
                        in1_rdy  = !f1_full && (seen_q || !f0_full);
                        f1_push  = in1_rdy;
                        // First inner data proves the fiber non-empty: release the outer coord.
                        f0_push  = in1_rdy && !seen_q && is_data(cmrg_coord_in_1);
                        f0_wdata = hold_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Remember handshake outputs so they stay put while clk_en is low.
    always_comb begin
        hs_d = clk_en ? hs_comb : hs_q;
    end

    // Held handshake register.
    always_ff @(posedge clk) begin
        if (rst_act) begin
            hs_q <= '0;
        end else begin
            hs_q <= hs_d;
        end
    end

    assign hs_comb = {in0_rdy, in1_rdy, out0_vld, out1_vld};

    // Handshake outputs: forced low under reset, frozen while clk_en is low.
    always_comb begin
        hs_out = hs_q;
        if (rst_act) begin
            hs_out = '0;
        end else if (clk_en) begin
            hs_out = hs_comb;
        end
    end

    assign cmrg_coord_in_0_ready  = hs_out[3];
    assign cmrg_coord_in_1_ready  = hs_out[2];
    assign cmrg_coord_out_0_valid = hs_out[1];
    assign cmrg_coord_out_1_valid = hs_out[0];
    assign cmrg_coord_out_0       = f0_rdata;
    assign cmrg_coord_out_1       = f1_rdata;

    reg_fifo #(
        .Depth (2),
        .Width (TOKEN_W)
    ) u_f0 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (flush),
        .en_i    (clk_en),
        .push_i  (f0_push),
        .wdata_i (f0_wdata),
        .pop_i   (f0_pop),
        .rdata_o (f0_rdata),
        .full_o  (f0_full),
        .empty_o (f0_empty)
    );

    reg_fifo #(
        .Depth (2),
        .Width (TOKEN_W)
    ) u_f1 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (flush),
        .en_i    (clk_en),
        .push_i  (f1_push),
        .wdata_i (f1_wdata),
        .pop_i   (f1_pop),
        .rdata_o (f1_rdata),
        .full_o  (f1_full),
        .empty_o (f1_empty)
    );

endmodule

// File: tb/tb_crddrop.sv
// Directed bench for crddrop: table of tile scenarios plus hand-written corner sequences.
module tb_crddrop;

    localparam logic [16:0] D  = 17'h10100;
    localparam logic [16:0] S0 = 17'h10000;
    localparam logic [16:0] S1 = 17'h10001;
    localparam logic [16:0] S2 = 17'h10002;
    localparam logic [16:0] Z  = 17'h00000;

    typedef struct {
        string       name;
        logic [16:0] o[10];
        int          no;
        logic [16:0] i[10];
        int          ni;
        logic [16:0] e0[10];
        int          ne0;
        logic [16:0] e1[10];
        int          ne1;
        int          bp0_s;
        int          bp0_l;
        int          ce_s;
        int          ce_l;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, clk_en, flush, tile_en;
    logic [16:0] in0, in1, out0, out1;
    logic        in0_valid, in0_ready, in1_valid, in1_ready;
    logic        out0_valid, out0_ready, out1_valid, out1_ready;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs[7];
    vec_t hv;

    always #5 clk = ~clk;

    crddrop dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .clk_en                 (clk_en),
        .flush                  (flush),
        .tile_en                (tile_en),
        .cmrg_coord_in_0        (in0),
        .cmrg_coord_in_0_valid  (in0_valid),
        .cmrg_coord_in_0_ready  (in0_ready),
        .cmrg_coord_in_1        (in1),
        .cmrg_coord_in_1_valid  (in1_valid),
        .cmrg_coord_in_1_ready  (in1_ready),
        .cmrg_coord_out_0       (out0),
        .cmrg_coord_out_0_valid (out0_valid),
        .cmrg_coord_out_0_ready (out0_ready),
        .cmrg_coord_out_1       (out1),
        .cmrg_coord_out_1_valid (out1_valid),
        .cmrg_coord_out_1_ready (out1_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in0_valid  = 1'b0;
        in1_valid  = 1'b0;
        in0        = '0;
        in1        = '0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        clk_en     = 1'b1;
        tile_en    = 1'b1;
        flush      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input bit rst);
        int          oi = 0;
        int          ii = 0;
        bit          done = 0;
        bit          stall, prev_stall = 0;
        bit          frozen_ok = 1;
        bit          bp_seen = 0;
        logic [3:0]  hs, hs_active = '0;
        logic [33:0] dat, prev_dat = '0;
        logic [16:0] got0[$];
        logic [16:0] got1[$];
        if (rst) do_reset();
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            stall      = (cyc >= v.ce_s) && (cyc < v.ce_s + v.ce_l);
            clk_en     = !stall;
            out0_ready = !((cyc >= v.bp0_s) && (cyc < v.bp0_s + v.bp0_l));
            out1_ready = 1'b1;
            in0_valid  = (oi < v.no);
            in0        = in0_valid ? v.o[oi] : Z;
            in1_valid  = (ii < v.ni);
            in1        = in1_valid ? v.i[ii] : Z;
            #1;
            hs  = {in0_ready, in1_ready, out0_valid, out1_valid};
            dat = {out0, out1};
            if (stall) begin
                if (hs !== hs_active) frozen_ok = 0;
                if (prev_stall && dat !== prev_dat) frozen_ok = 0;
            end else begin
                hs_active = hs;
                if (in1_valid && !in1_ready && out0_valid && !out0_ready) bp_seen = 1;
            end
            prev_stall = stall;
            prev_dat   = dat;
            if (clk_en) begin
                if (in0_valid && in0_ready) oi++;
                if (in1_valid && in1_ready) ii++;
                if (out0_valid && out0_ready) got0.push_back(out0);
                if (out1_valid && out1_ready) got1.push_back(out1);
            end
            done = (oi == v.no) && (ii == v.ni) && (got0.size() >= v.ne0) &&
                   (got1.size() >= v.ne1);
        end
        check({v.name, " completes in budget"}, 32'(done), 32'd1);
        // Drain a few idle cycles so stray extra tokens show up in the counts.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            if (out0_valid) got0.push_back(out0);
            if (out1_valid) got1.push_back(out1);
        end
        check({v.name, " out0 count"}, 32'(got0.size()), 32'(v.ne0));
        check({v.name, " out1 count"}, 32'(got1.size()), 32'(v.ne1));
        for (int k = 0; k < v.ne0 && k < got0.size(); k++) begin
            check($sformatf("%s out0[%0d]", v.name, k), 32'(got0[k]), 32'(v.e0[k]));
        end
        for (int k = 0; k < v.ne1 && k < got1.size(); k++) begin
            check($sformatf("%s out1[%0d]", v.name, k), 32'(got1[k]), 32'(v.e1[k]));
        end
        if (v.ce_l > 0) check({v.name, " frozen during stall"}, 32'(frozen_ok), 32'd1);
        if (v.bp0_l > 0) check({v.name, " in1 ready drop on F0 full"}, 32'(bp_seen), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        idle_inputs();

        vecs[0].name = "basic";
        vecs[0].o  = '{17'd5, 17'd7, S0, D, Z, Z, Z, Z, Z, Z};          vecs[0].no  = 4;
        vecs[0].i  = '{17'd3, S0, S1, D, Z, Z, Z, Z, Z, Z};             vecs[0].ni  = 4;
        vecs[0].e0 = '{17'd5, S0, D, Z, Z, Z, Z, Z, Z, Z};              vecs[0].ne0 = 3;
        vecs[0].e1 = '{17'd3, S0, S1, D, Z, Z, Z, Z, Z, Z};             vecs[0].ne1 = 4;

        vecs[1].name = "all_empty";
        vecs[1].o  = '{17'd2, 17'd4, S0, D, Z, Z, Z, Z, Z, Z};          vecs[1].no  = 4;
        vecs[1].i  = '{S0, S1, D, Z, Z, Z, Z, Z, Z, Z};                 vecs[1].ni  = 3;
        vecs[1].e0 = '{S0, D, Z, Z, Z, Z, Z, Z, Z, Z};                  vecs[1].ne0 = 2;
        vecs[1].e1 = '{S0, S1, D, Z, Z, Z, Z, Z, Z, Z};                 vecs[1].ne1 = 3;

        vecs[2].name = "backpressure";
        vecs[2].o  = '{17'd1, 17'd2, 17'd3, 17'd4, S0, D, Z, Z, Z, Z};  vecs[2].no  = 6;
        vecs[2].i  = '{17'd11, S0, 17'd12, S0, 17'd13, S0, 17'd14, S1, D, Z};
        vecs[2].ni = 9;
        vecs[2].e0 = '{17'd1, 17'd2, 17'd3, 17'd4, S0, D, Z, Z, Z, Z};  vecs[2].ne0 = 6;
        vecs[2].e1 = '{17'd11, S0, 17'd12, S0, 17'd13, S0, 17'd14, S1, D, Z};
        vecs[2].ne1 = 9;
        vecs[2].bp0_s = 2;
        vecs[2].bp0_l = 10;

        vecs[3] = vecs[0];
        vecs[3].name = "clk_en_stall";
        vecs[3].ce_s = 3;
        vecs[3].ce_l = 5;

        vecs[4].name = "two_tiles";
        vecs[4].o  = '{17'd5, 17'd7, S0, D, 17'd2, S0, D, Z, Z, Z};     vecs[4].no  = 7;
        vecs[4].i  = '{17'd3, S0, S1, D, 17'd4, S0, D, Z, Z, Z};        vecs[4].ni  = 7;
        vecs[4].e0 = '{17'd5, S0, D, 17'd2, S0, D, Z, Z, Z, Z};         vecs[4].ne0 = 6;
        vecs[4].e1 = '{17'd3, S0, S1, D, 17'd4, S0, D, Z, Z, Z};        vecs[4].ne1 = 7;

        vecs[5].name = "stop_levels";
        vecs[5].o  = '{17'd8, S1, D, Z, Z, Z, Z, Z, Z, Z};              vecs[5].no  = 3;
        vecs[5].i  = '{17'd6, 17'd7, S2, D, Z, Z, Z, Z, Z, Z};          vecs[5].ni  = 4;
        vecs[5].e0 = '{17'd8, S1, D, Z, Z, Z, Z, Z, Z, Z};              vecs[5].ne0 = 3;
        vecs[5].e1 = '{17'd6, 17'd7, S2, D, Z, Z, Z, Z, Z, Z};          vecs[5].ne1 = 4;

        vecs[6].name = "done_in_hold";
        vecs[6].o  = '{17'd5, D, Z, Z, Z, Z, Z, Z, Z, Z};               vecs[6].no  = 2;
        vecs[6].i  = '{D, Z, Z, Z, Z, Z, Z, Z, Z, Z};                   vecs[6].ni  = 1;
        vecs[6].e0 = '{D, Z, Z, Z, Z, Z, Z, Z, Z, Z};                   vecs[6].ne0 = 1;
        vecs[6].e1 = '{D, Z, Z, Z, Z, Z, Z, Z, Z, Z};                   vecs[6].ne1 = 1;

        hv.name = "after_flush";
        hv.o  = '{17'd9, D, Z, Z, Z, Z, Z, Z, Z, Z};                    hv.no  = 2;
        hv.i  = '{17'd1, S0, D, Z, Z, Z, Z, Z, Z, Z};                   hv.ni  = 3;
        hv.e0 = '{17'd9, D, Z, Z, Z, Z, Z, Z, Z, Z};                    hv.ne0 = 2;
        hv.e1 = '{17'd1, S0, D, Z, Z, Z, Z, Z, Z, Z};                   hv.ne1 = 3;

        // Reset cycle: everything low even with inputs offered and clk_en low.
        @(negedge clk);
        rst_n     = 1'b0;
        clk_en    = 1'b0;
        in0_valid = 1'b1;
        in0       = 17'd5;
        in1_valid = 1'b1;
        in1       = D;
        #1;
        check("reset in0_ready", 32'(in0_ready), 32'd0);
        check("reset in1_ready", 32'(in1_ready), 32'd0);
        check("reset out0_valid", 32'(out0_valid), 32'd0);
        check("reset out1_valid", 32'(out1_valid), 32'd0);
        @(negedge clk);
        #1;
        check("reset out0 data", 32'(out0), 32'd0);
        check("reset out1 data", 32'(out1), 32'd0);
        rst_n = 1'b1;
        idle_inputs();

        foreach (vecs[k]) run_vec(vecs[k], 1'b1);

        // IDLE stall on inner data, tile_en gating, HOLD readiness, 1-cycle latency, flush.
        do_reset();
        @(negedge clk);
        in1_valid  = 1'b1;
        in1        = 17'd3;
        in0_valid  = 1'b1;
        in0        = 17'd5;
        tile_en    = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #1;
        check("tile_en=0 in0_ready", 32'(in0_ready), 32'd0);
        tile_en = 1'b1;
        #1;
        check("idle in0_ready outer data", 32'(in0_ready), 32'd1);
        check("idle in1_ready inner data stalls", 32'(in1_ready), 32'd0);
        @(negedge clk);
        in0_valid = 1'b0;
        #1;
        check("hold in0_ready", 32'(in0_ready), 32'd0);
        check("hold in1_ready", 32'(in1_ready), 32'd1);
        @(negedge clk);
        in1_valid = 1'b0;
        #1;
        check("latency out0_valid", 32'(out0_valid), 32'd1);
        check("latency out0 data", 32'(out0), 32'd5);
        check("latency out1_valid", 32'(out1_valid), 32'd1);
        check("latency out1 data", 32'(out1), 32'd3);
        flush = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        in0_valid = 1'b1;
        in0       = 17'd9;
        #1;
        check("flush out0_valid", 32'(out0_valid), 32'd0);
        check("flush out1_valid", 32'(out1_valid), 32'd0);
        check("flush out0 data", 32'(out0), 32'd0);
        check("flush back to idle", 32'(in0_ready), 32'd1);
        in0_valid = 1'b0;
        run_vec(hv, 1'b0);

        // Reset wins over clk_en=0 while holding a coordinate.
        do_reset();
        @(negedge clk);
        in0_valid = 1'b1;
        in0       = 17'd5;
        @(negedge clk);
        in0_valid = 1'b0;
        rst_n     = 1'b0;
        clk_en    = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        clk_en    = 1'b1;
        in0_valid = 1'b1;
        in0       = 17'd6;
        #1;
        check("reset over clk_en idle", 32'(in0_ready), 32'd1);
        in0_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
